mont_word_packer: RTL and testbench

Bidirectional width adapter between the 32-bit host-side word stream and `NUM_CORES` Montgomery cores with `OPERAND_BITS`-wide operands. It sits in the interface layer between the host-facing register/BRAM logic and the core array. The ingress path assembles 32-bit words into a full operand and dispatches it to the core named in the first word. The egress path arbitrates among finished cores, captures one result, and streams it back as 32-bit words tagged with the core index.

---
 rtl/mont_wp_pkg.sv | 14 +
 rtl/mont_wp_arbiter.sv | 53 +++++
 rtl/mont_word_packer.sv | 132 +++++++++++++
 tb/tb_mont_word_packer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_wp_pkg.sv
// mont_wp_pkg: shared word width, FSM state types and index-width helper for mont_word_packer
package mont_wp_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {IN_FILL, IN_HOLD} in_state_t;
    typedef enum logic {EG_IDLE, EG_SEND} eg_state_t;

    // Index width for n items, never narrower than one bit
    function automatic int cidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mont_wp_arbiter.sv
// mont_wp_arbiter: picks one pending core result; round-robin under MONT_WP_ROUND_ROBIN_EN, else lowest index wins
module mont_wp_arbiter
    import mont_wp_pkg::*;
#(
    parameter int NUM_CORES = 2,
    localparam int CIDX_W = cidx_w(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 adv,
    output logic [NUM_CORES-1:0] gnt,
    output logic [CIDX_W-1:0]    sel
);

`ifdef MONT_WP_ROUND_ROBIN_EN
    logic [CIDX_W-1:0]  ptr;
    logic [NUM_CORES-1:0] rot;
    logic [CIDX_W:0]    off;
    logic [CIDX_W:0]    sum;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, then undo the rotation
    always_comb begin
        rot = NUM_CORES'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (rot[i]) off = (CIDX_W+1)'(i);
        sum = {1'b0, ptr} + off;
        sel = (sum >= (CIDX_W+1)'(NUM_CORES)) ? CIDX_W'(sum - (CIDX_W+1)'(NUM_CORES)) : CIDX_W'(sum);
    end

    // Search pointer moves to the core just after the winner on every grant
    always_ff @(posedge clk or posedge rst)
        if (rst)
            ptr <= '0;
        else if (adv)
            ptr <= (sel == CIDX_W'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
`else
    logic unused_ok;

    assign unused_ok = &{1'b0, clk, rst, adv};

    // Lowest pending index wins
    always_comb begin
        sel = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (req[i]) sel = CIDX_W'(i);
    end
`endif

    assign gnt = (|req) ? NUM_CORES'(1) << sel : '0;

endmodule

// File: rtl/mont_word_packer.sv
// mont_word_packer: 32-bit host word stream <-> NUM_CORES Montgomery cores with OPERAND_BITS-wide operands
// Build option MONT_WP_ROUND_ROBIN_EN makes egress arbitration round-robin (default: fixed priority)
module mont_word_packer
    import mont_wp_pkg::*;
#(
    parameter int OPERAND_BITS = 512,
    parameter int NUM_CORES = 2,
    localparam int WORDS = OPERAND_BITS / WORD_W,
    localparam int CIDX_W = cidx_w(NUM_CORES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WORD_W-1:0]                 in_data,
    input  logic [CIDX_W-1:0]                 in_core,
    input  logic                              in_last,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [OPERAND_BITS-1:0]           core_din,
    output logic [NUM_CORES-1:0]              core_din_valid,
    input  logic [NUM_CORES-1:0]              core_din_ready,
    input  logic [NUM_CORES*OPERAND_BITS-1:0] core_dout,
    input  logic [NUM_CORES-1:0]              core_dout_valid,
    output logic [NUM_CORES-1:0]              core_dout_read,
    output logic [WORD_W-1:0]                 out_data,
    output logic [CIDX_W-1:0]                 out_core,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              err_frame
);

    localparam int CNT_W = cidx_w(WORDS);
    localparam int OK_W = 2 ** CIDX_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
    // Bit c set when core index c exists; lets out-of-range indices be flagged by a lookup
    localparam logic [OK_W-1:0] CORE_OK = OK_W'((1 << NUM_CORES) - 1);

    in_state_t          in_state, in_next;
    logic [CNT_W-1:0]   in_cnt;
    logic [CIDX_W-1:0]  in_sel;
    logic               in_acc, in_err, in_done;

    eg_state_t              eg_state, eg_next;
    logic [CNT_W-1:0]       eg_cnt;
    logic [OPERAND_BITS-1:0] eg_shift;
    logic [NUM_CORES-1:0]   gnt;
    logic [CIDX_W-1:0]      sel;
    logic                   eg_cap, eg_fire;

    // ---------------- ingress ----------------
    assign in_ready       = in_state == IN_FILL;
    assign in_acc         = in_valid && in_ready;
    assign in_err         = (in_last && in_cnt != LAST_IDX) || (in_cnt == '0 && !CORE_OK[in_core]);
    assign in_done        = in_acc && !in_err && in_cnt == LAST_IDX;
    assign core_din_valid = (in_state == IN_HOLD) ? NUM_CORES'(1) << in_sel : '0;

    // Ingress state register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            in_state <= IN_FILL;
        else
            in_state <= in_next;

    // Hold a completed operand until the addressed core takes it
    always_comb begin
        in_next = in_done ? IN_HOLD : (in_state == IN_HOLD && |(core_din_valid & core_din_ready)) ? IN_FILL : in_state;
    end

    // Word assembly, core latch and framing-error pulse; an errored frame restarts at word 0
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            core_din  <= '0;
            in_cnt    <= '0;
            in_sel    <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= in_acc && in_err;
            if (in_acc) begin
                in_cnt <= (in_err || in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
                if (!in_err) begin
                    for (int k = 0; k < WORDS; k++)
                        if (in_cnt == CNT_W'(k)) core_din[k*WORD_W +: WORD_W] <= in_data;
                    if (in_cnt == '0) in_sel <= in_core;
                end
            end
        end

    // ---------------- egress ----------------
    assign eg_cap         = eg_state == EG_IDLE && |core_dout_valid;
    assign eg_fire        = out_valid && out_ready;
    assign core_dout_read = (eg_state == EG_IDLE && !rst) ? gnt : '0;
    assign out_valid      = eg_state == EG_SEND;
    assign out_data       = eg_shift[WORD_W-1:0];
    assign out_last       = out_valid && eg_cnt == LAST_IDX;

    mont_wp_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (core_dout_valid),
        .adv (eg_cap),
        .gnt (gnt),
        .sel (sel)
    );

    // Egress state register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            eg_state <= EG_IDLE;
        else
            eg_state <= eg_next;

    // Capture one result, then stream it until the last word is taken
    always_comb begin
        eg_next = eg_cap ? EG_SEND : (eg_fire && out_last) ? EG_IDLE : eg_state;
    end

    // Result capture and word-by-word shift-out; the emptied register reads back as zero
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            eg_shift <= '0;
            eg_cnt   <= '0;
            out_core <= '0;
        end else if (eg_cap) begin
            for (int i = 0; i < NUM_CORES; i++)
                if (sel == CIDX_W'(i)) eg_shift <= core_dout[i*OPERAND_BITS +: OPERAND_BITS];
            out_core <= sel;
        end else if (eg_fire) begin
            eg_shift <= eg_shift >> WORD_W;
            eg_cnt   <= out_last ? '0 : eg_cnt + 1'b1;
        end

endmodule

// File: tb/tb_mont_word_packer.sv
// tb_mont_word_packer: scoreboard bench for mont_word_packer (512-bit operands, 2 cores)
module tb_mont_word_packer;

    localparam int OB = 512;
    localparam int NC = 2;
    localparam int WORDS = 16;
    localparam int CW = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       in_data = '0;
    logic [CW-1:0]     in_core = '0;
    logic              in_last = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OB-1:0]     core_din;
    logic [NC-1:0]     core_din_valid;
    logic [NC-1:0]     core_din_ready = '1;
    logic [NC*OB-1:0]  core_dout;
    logic [NC-1:0]     core_dout_valid;
    logic [NC-1:0]     core_dout_read;
    logic [31:0]       out_data;
    logic [CW-1:0]     out_core;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              err_frame;

    typedef struct {
        logic [NC-1:0] vld;
        logic [OB-1:0] data;
    } din_t;

    typedef struct {
        logic [31:0]   data;
        logic [CW-1:0] core;
        logic          last;
    } eg_t;

    din_t          din_q[$];
    eg_t           eg_q[$];
    logic [OB-1:0] res_q[NC][$];
    int            err_exp = 0;
    int            checks = 0;
    int            errors = 0;
    int            rdy_mode = 0;

    mont_word_packer #(.OPERAND_BITS(OB), .NUM_CORES(NC)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_core         (in_core),
        .in_last         (in_last),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .core_din        (core_din),
        .core_din_valid  (core_din_valid),
        .core_din_ready  (core_din_ready),
        .core_dout       (core_dout),
        .core_dout_valid (core_dout_valid),
        .core_dout_read  (core_dout_read),
        .out_data        (out_data),
        .out_core        (out_core),
        .out_last        (out_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .err_frame       (err_frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OB-1:0] act, input logic [OB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [7:0] tag, input int k);
        return {tag, 16'h0000, 8'(k)};
    endfunction

    function automatic logic [OB-1:0] mk(input logic [7:0] tag);
        logic [OB-1:0] r;
        for (int k = 0; k < WORDS; k++) r[k*32 +: 32] = word(tag, k);
        return r;
    endfunction

    task automatic expect_result(input logic [7:0] tag, input int c);
        eg_t e;
        for (int k = 0; k < WORDS; k++) begin
            e.data = word(tag, k);
            e.core = CW'(c);
            e.last = (k == WORDS - 1);
            eg_q.push_back(e);
        end
    endtask

    // Core model: results queue per core; a read pulse retires the head after the capture edge
    initial begin : core_model
        logic [NC-1:0] rd;
        core_dout = '0;
        core_dout_valid = '0;
        forever begin
            @(negedge clk);
            rd = core_dout_read;
            @(posedge clk);
            #2;
            for (int i = 0; i < NC; i++) begin
                if (rd[i] && res_q[i].size() > 0) void'(res_q[i].pop_front());
                core_dout_valid[i] = res_q[i].size() > 0;
                core_dout[i*OB +: OB] = (res_q[i].size() > 0) ? res_q[i][0] : '0;
            end
        end
    end

    // Egress backpressure: steady ready or toggling every cycle
    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode != 0) ? ~out_ready : 1'b1;
        end
    end

    // Ingress monitor: dispatch handshakes and framing-error pulses
    initial begin : ing_mon
        din_t d;
        forever begin
            @(negedge clk);
            if (err_frame) begin
                chk("err_frame_expected", 1'(err_exp > 0), 1'b1);
                if (err_exp > 0) err_exp--;
            end
            if (|(core_din_valid & core_din_ready)) begin
                if (din_q.size() == 0)
                    chk("unexpected_dispatch", core_din_valid, '0);
                else begin
                    d = din_q.pop_front();
                    chk("dispatch_valid", core_din_valid, d.vld);
                    chk("dispatch_data", core_din, d.data);
                end
            end
        end
    end

    // Egress monitor: word order, capture-to-valid latency, stability under backpressure
    initial begin : eg_mon
        eg_t  e;
        logic rd_prev = 1'b0;
        logic pv = 1'b0;
        logic pr = 1'b1;
        logic [33:0] snap = '0;
        forever begin
            @(negedge clk);
            chk("read_onehot", 1'($onehot0(core_dout_read)), 1'b1);
            if (!rst && rd_prev) chk("valid_after_capture", out_valid, 1'b1);
            if (!rst && pv && !pr) chk("hold_stable", {out_valid, out_data, out_core, out_last}, {1'b1, snap});
            if (out_valid && out_ready) begin
                if (eg_q.size() == 0)
                    chk("unexpected_output", out_valid, 1'b0);
                else begin
                    e = eg_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_core", out_core, e.core);
                    chk("out_last", out_last, e.last);
                end
            end
            rd_prev = |core_dout_read;
            pv = out_valid;
            pr = out_ready;
            snap = {out_data, out_core, out_last};
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [CW-1:0] c, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data = d;
        in_core = c;
        in_last = l;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ingress_accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // n words base+k; term puts in_last on the final word
    task automatic send_frame(input logic [CW-1:0] c, input logic [31:0] base, input int n, input logic term);
        din_t d;
        d.vld = NC'(1) << c;
        d.data = '0;
        for (int k = 0; k < n; k++) d.data[k*32 +: 32] = base + 32'(k);
        if (n == WORDS) din_q.push_back(d);
        else if (term) err_exp++;
        for (int k = 0; k < n; k++) send_word(base + 32'(k), c, term && (k == n - 1));
        if (n == WORDS || term) begin
            @(negedge clk);
            chk("dispatch_latency", core_din_valid, (n == WORDS) ? d.vld : '0);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((eg_q.size() != 0 || din_q.size() != 0 || err_exp != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", eg_q.size() + din_q.size() + err_exp, 0);
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_core_din", core_din, '0);
        chk("rst_core_din_valid", core_din_valid, '0);
        chk("rst_core_dout_read", core_dout_read, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_core", out_core, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_err_frame", err_frame, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Dispatch to core 1 while the core withholds ready
        core_din_ready = 2'b00;
        send_frame(1'b1, 32'h0, WORDS, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_din_valid", core_din_valid, 2'b10);
        end
        chk("din_word0", core_din[31:0], 32'h0);
        chk("din_word15", core_din[511:480], 32'hF);
        @(posedge clk);
        #1;
        core_din_ready = 2'b11;
        repeat (2) @(negedge clk);
        chk("in_ready_after_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Early in_last on word 5, then a clean frame to core 0
        send_frame(1'b0, 32'h0, 6, 1'b1);
        @(posedge clk);
        #1;
        send_frame(1'b0, 32'h100, WORDS, 1'b1);
        wait_drain();

        // Arbitration order with toggling out_ready
        rdy_mode = 1;
`ifdef MONT_WP_ROUND_ROBIN_EN
        expect_result(8'h11, 0);
        expect_result(8'h22, 1);
        expect_result(8'h33, 0);
        expect_result(8'h44, 0);
`else
        expect_result(8'h11, 0);
        expect_result(8'h33, 0);
        expect_result(8'h44, 0);
        expect_result(8'h22, 1);
`endif
        res_q[0].push_back(mk(8'h11));
        res_q[0].push_back(mk(8'h33));
        res_q[0].push_back(mk(8'h44));
        res_q[1].push_back(mk(8'h22));
        wait_drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Ingress and egress at the same time
        expect_result(8'h55, 1);
        res_q[1].push_back(mk(8'h55));
        send_frame(1'b1, 32'h200, WORDS, 1'b1);
        wait_drain();
        @(posedge clk);
        #1;

        // Reset with 7 ingress words buffered and a result mid-stream
        send_frame(1'b0, 32'h300, 7, 1'b0);
        expect_result(8'h66, 0);
        res_q[0].push_back(mk(8'h66));
        for (int t = 0; t < 200 && eg_q.size() > 10; t++) @(negedge clk);
        chk("egress_started", 1'(eg_q.size() <= 10), 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        eg_q.delete();
        res_q[0].delete();
        res_q[1].delete();
        #2;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_mid_rst", in_ready, 1'b1);
        chk("out_valid_after_mid_rst", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Clean traffic after reset
        expect_result(8'h77, 1);
        res_q[1].push_back(mk(8'h77));
        send_frame(1'b0, 32'h400, WORDS, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
